raycast_mem_slave: RTL and testbench

RAYCAST_MEM_SLAVE -- requirements
Module: raycast_mem_slave

---
 rtl/raycast_mem_slave.sv | 169 ++++++++++++++++
 tb/tb_raycast_mem_slave.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/raycast_mem_slave.sv
// raycast_mem_slave
//   Wishbone B4 registered-feedback memory slave holding 2^MEM_AW 32-bit words
//   at byte window BASE_ADR. Supports classic cycles and incrementing bursts
//   (linear, wrap-4, wrap-8, wrap-16) with WAIT_STATES cycles before the
//   first beat of every bus cycle and no wait states between burst beats.
//
// Ports
//   wb_clk       clock, rising edge
//   wb_rst       asynchronous active-high reset
//   s_wb_adr_i   byte address (bits [1:0] ignored)
//   s_wb_sel_i   byte-lane write enables
//   s_wb_we_i    1 = write, 0 = read
//   s_wb_dat_i   write data
//   s_wb_dat_o   registered read data
//   s_wb_cyc_i   bus cycle
//   s_wb_stb_i   strobe
//   s_wb_ack_o   registered normal termination
//   s_wb_err_o   registered error termination (address outside the window)
//   s_wb_cti_i   cycle type: 000 classic, 010 incrementing, 111 end-of-burst
//   s_wb_bte_i   burst type: 00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16
//   dbg_state    current FSM state (0 IDLE, 1 WAIT, 2 BURST, 3 DONE)
//
// Handshake: a beat completes at every rising edge where the FSM is in BURST
// and cyc and stb are both high; ack (or err) is high for the cycle after that
// edge. The master must present the cti of the next beat right after it sees
// the ack of the current one; cti 010 keeps the burst going, anything else
// makes the beat the last one.
module raycast_mem_slave #(
  parameter int          MEM_AW      = 10,
  parameter logic [31:0] BASE_ADR    = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic [31:0] s_wb_adr_i,
  input  logic [3:0]  s_wb_sel_i,
  input  logic        s_wb_we_i,
  input  logic [31:0] s_wb_dat_i,
  output logic [31:0] s_wb_dat_o,
  input  logic        s_wb_cyc_i,
  input  logic        s_wb_stb_i,
  output logic        s_wb_ack_o,
  output logic        s_wb_err_o,
  input  logic [2:0]  s_wb_cti_i,
  input  logic [1:0]  s_wb_bte_i,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_BURST = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // WAIT is entered with the counter at WAIT_STATES-1 so that it lasts
  // exactly WAIT_STATES cycles.
  localparam int         WAIT_LOAD_I = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
  localparam logic [2:0] WAIT_LOAD   = WAIT_LOAD_I[2:0];

  logic [31:0]       mem [2**MEM_AW];

  logic [1:0]        state;
  logic [2:0]        wait_cnt;
  logic [MEM_AW-1:0] word_adr;
  logic              we_q;
  logic [1:0]        bte_q;
  logic              in_range_q;

  logic [31:0]       offset;
  logic              in_range;
  logic              beat;
  logic              mem_we;
  logic [MEM_AW-1:0] adr_inc;
  logic [MEM_AW-1:0] wrap_mask;
  logic [MEM_AW-1:0] adr_next;

  assign dbg_state = state;

  // Addresses below BASE_ADR wrap to a huge offset and fall out of range.
  assign offset   = s_wb_adr_i - BASE_ADR;
  assign in_range = ((offset >> (MEM_AW + 2)) == 32'd0);

  assign beat   = (state == S_BURST) && s_wb_cyc_i && s_wb_stb_i;
  assign mem_we = beat && we_q && in_range_q && !wb_rst;

  // Wrapping bursts only advance the low word-address bits inside the
  // aligned 4/8/16-word block; linear bursts advance the whole address.
  always_comb begin
    adr_inc   = word_adr + 1'b1;
    wrap_mask = '1;
    case (bte_q)
      2'b01:   wrap_mask = {{(MEM_AW-4){1'b0}}, 4'b0011};
      2'b10:   wrap_mask = {{(MEM_AW-4){1'b0}}, 4'b0111};
      2'b11:   wrap_mask = {{(MEM_AW-4){1'b0}}, 4'b1111};
      default: wrap_mask = '1;
    endcase
    adr_next = (word_adr & ~wrap_mask) | (adr_inc & wrap_mask);
  end

  // Memory is never cleared by reset; writes are gated by the FSM, which
  // reset forces out of BURST immediately.
  always_ff @(posedge wb_clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (s_wb_sel_i[i]) mem[word_adr][8*i +: 8] <= s_wb_dat_i[8*i +: 8];
      end
    end
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state      <= S_IDLE;
      wait_cnt   <= 3'd0;
      word_adr   <= '0;
      we_q       <= 1'b0;
      bte_q      <= 2'b00;
      in_range_q <= 1'b0;
      s_wb_ack_o <= 1'b0;
      s_wb_err_o <= 1'b0;
      s_wb_dat_o <= 32'd0;
    end else begin
      s_wb_ack_o <= 1'b0;
      s_wb_err_o <= 1'b0;
      if (!s_wb_cyc_i) begin
        state    <= S_IDLE;
        wait_cnt <= 3'd0;
      end else begin
        case (state)
          S_IDLE: begin
            if (s_wb_stb_i) begin
              word_adr   <= offset[MEM_AW+1:2];
              in_range_q <= in_range;
              we_q       <= s_wb_we_i;
              bte_q      <= s_wb_bte_i;
              if (WAIT_STATES > 0) begin
                state    <= S_WAIT;
                wait_cnt <= WAIT_LOAD;
              end else begin
                state <= S_BURST;
              end
            end
          end
          S_WAIT: begin
            if (wait_cnt == 3'd0) state <= S_BURST;
            else                  wait_cnt <= wait_cnt - 3'd1;
          end
          S_BURST: begin
            // stb low while cyc high is a pause: nothing changes.
            if (s_wb_stb_i) begin
              if (in_range_q) begin
                s_wb_ack_o <= 1'b1;
                if (!we_q) s_wb_dat_o <= mem[word_adr];
              end else begin
                s_wb_err_o <= 1'b1;
                s_wb_dat_o <= 32'd0;
              end
              if (s_wb_cti_i == 3'b010) word_adr <= adr_next;
              else                      state    <= S_DONE;
            end
          end
          default: begin
            // DONE: one dead cycle, stb ignored.
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_raycast_mem_slave.sv
module tb_raycast_mem_slave;

  localparam int          MEM_AW      = 10;
  localparam logic [31:0] BASE_ADR    = 32'h0000_0000;
  localparam int          WAIT_STATES = 1;
  localparam int          N           = 1 << MEM_AW;

  // ---------------- clock / reset / DUT ----------------
  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic [31:0] s_wb_adr_i;
  logic [3:0]  s_wb_sel_i;
  logic        s_wb_we_i;
  logic [31:0] s_wb_dat_i;
  logic [31:0] s_wb_dat_o;
  logic        s_wb_cyc_i;
  logic        s_wb_stb_i;
  logic        s_wb_ack_o;
  logic        s_wb_err_o;
  logic [2:0]  s_wb_cti_i;
  logic [1:0]  s_wb_bte_i;
  logic [1:0]  dbg_state;

  always #5 wb_clk = ~wb_clk;

  raycast_mem_slave #(
    .MEM_AW     (MEM_AW),
    .BASE_ADR   (BASE_ADR),
    .WAIT_STATES(WAIT_STATES)
  ) dut (
    .wb_clk    (wb_clk),
    .wb_rst    (wb_rst),
    .s_wb_adr_i(s_wb_adr_i),
    .s_wb_sel_i(s_wb_sel_i),
    .s_wb_we_i (s_wb_we_i),
    .s_wb_dat_i(s_wb_dat_i),
    .s_wb_dat_o(s_wb_dat_o),
    .s_wb_cyc_i(s_wb_cyc_i),
    .s_wb_stb_i(s_wb_stb_i),
    .s_wb_ack_o(s_wb_ack_o),
    .s_wb_err_o(s_wb_err_o),
    .s_wb_cti_i(s_wb_cti_i),
    .s_wb_bte_i(s_wb_bte_i),
    .dbg_state (dbg_state)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [31:0] ref_mem   [N];
  bit          ref_known [N];
  logic [31:0] exp_q[$];
  bit          known_q[$];
  logic [31:0] fix_q[$];
  logic [31:0] last_dat;
  bit          last_known;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Next word address of a burst, from the burst-type rule.
  function automatic int next_w(input int w, input logic [1:0] bte);
    int size;
    size = (bte == 2'b01) ? 4 : (bte == 2'b10) ? 8 : (bte == 2'b11) ? 16 : 0;
    if (size == 0) return (w + 1) % N;
    return (w / size) * size + ((w % size) + 1) % size;
  endfunction

  // ---------------- driver ----------------
  // pause_at: stb dropped for 2 cycles after that many beats completed.
  // abort_at: reset asserted after that many beats completed.
  task automatic do_burst(input logic [31:0] badr, input logic wr, input logic [1:0] bte,
                          input int nbeats, input logic [3:0] sel,
                          input int pause_at, input int abort_at);
    logic [31:0] off;
    logic        ok;
    int          w;
    int          beat_w[$];
    int          beat;
    int          cyc_cnt;
    logic [31:0] e;
    bit          k;
    logic [31:0] wdat;
    logic [31:0] cur;

    off = badr - BASE_ADR;
    ok  = (off < 32'(N * 4));
    w   = int'(off[MEM_AW+1:2]);
    exp_q.delete();
    known_q.delete();
    for (int b = 0; b < nbeats; b++) begin
      beat_w.push_back(w);
      if (!ok) begin
        last_dat = 32'd0; last_known = 1'b1;
      end else if (!wr) begin
        last_dat = ref_mem[w]; last_known = ref_known[w];
      end
      exp_q.push_back(last_dat);
      known_q.push_back(last_known);
      w = next_w(w, bte);
    end

    wdat = (fix_q.size() > 0) ? fix_q.pop_front() : $urandom;
    s_wb_cyc_i = 1'b1; s_wb_stb_i = 1'b1; s_wb_we_i = wr; s_wb_adr_i = badr;
    s_wb_sel_i = sel; s_wb_bte_i = bte; s_wb_dat_i = wdat;
    if (nbeats == 1) s_wb_cti_i = ($urandom_range(0, 1) == 1) ? 3'b111 : 3'b000;
    else             s_wb_cti_i = 3'b010;

    beat = 0; cyc_cnt = 0;
    while (beat < nbeats) begin
      @(posedge wb_clk); #1;
      cyc_cnt++;
      check("ack_err_excl", 32'(s_wb_ack_o & s_wb_err_o), 32'd0);
      if (s_wb_ack_o || s_wb_err_o) begin
        if (beat == 0) check("first_latency", 32'(cyc_cnt), 32'(WAIT_STATES + 2));
        check("ack", 32'(s_wb_ack_o), 32'(ok));
        check("err", 32'(s_wb_err_o), 32'(!ok));
        e = exp_q.pop_front();
        k = known_q.pop_front();
        if (k) check("dat_o", s_wb_dat_o, e);
        if (wr && ok) begin
          cur = ref_mem[beat_w[beat]];
          for (int i = 0; i < 4; i++) if (sel[i]) cur[8*i +: 8] = wdat[8*i +: 8];
          ref_mem[beat_w[beat]]   = cur;
          ref_known[beat_w[beat]] = ref_known[beat_w[beat]] | (sel == 4'hf);
        end
        beat++;
        if (beat < nbeats) begin
          if (beat == abort_at) begin
            wb_rst = 1'b1;
            #1;
            check("rst_ack_err", {30'd0, s_wb_ack_o, s_wb_err_o}, 32'd0);
            check("rst_dat_o", s_wb_dat_o, 32'd0);
            s_wb_cyc_i = 1'b0; s_wb_stb_i = 1'b0;
            @(posedge wb_clk); #1;
            wb_rst = 1'b0;
            last_dat = 32'd0; last_known = 1'b1;
            exp_q.delete(); known_q.delete();
            return;
          end
          wdat = (fix_q.size() > 0) ? fix_q.pop_front() : $urandom;
          s_wb_dat_i = wdat;
          s_wb_adr_i = BASE_ADR + 32'(beat_w[beat] * 4);
          s_wb_cti_i = (beat == nbeats - 1) ? 3'b111 : 3'b010;
          if (beat == pause_at) begin
            s_wb_stb_i = 1'b0;
            repeat (2) begin
              @(posedge wb_clk); #1;
              check("pause_ack_err", {30'd0, s_wb_ack_o, s_wb_err_o}, 32'd0);
            end
            s_wb_stb_i = 1'b1;
          end
        end
      end else begin
        if (beat > 0) check("burst_gap", 32'd0, 32'd1);
        if (cyc_cnt > 40) begin
          check("timeout", 32'd0, 32'd1);
          break;
        end
      end
    end

    // DONE cycle: strobe still held with a harmless classic read; it must be ignored.
    s_wb_we_i = 1'b0; s_wb_cti_i = 3'b000;
    @(posedge wb_clk); #1;
    check("done_gap", {30'd0, s_wb_ack_o, s_wb_err_o}, 32'd0);
    s_wb_cyc_i = 1'b0; s_wb_stb_i = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] badr;
    int          nb;
    logic [1:0]  bte;
    logic [3:0]  sel;
    logic        wr;

    for (int i = 0; i < N; i++) begin ref_mem[i] = 32'd0; ref_known[i] = 1'b0; end
    last_dat = 32'd0; last_known = 1'b1;
    wb_rst = 1'b1;
    s_wb_adr_i = 32'd0; s_wb_sel_i = 4'h0; s_wb_we_i = 1'b0; s_wb_dat_i = 32'd0;
    s_wb_cyc_i = 1'b0; s_wb_stb_i = 1'b0; s_wb_cti_i = 3'b000; s_wb_bte_i = 2'b00;

    repeat (3) @(posedge wb_clk);
    #1;
    check("reset_ack", 32'(s_wb_ack_o), 32'd0);
    check("reset_err", 32'(s_wb_err_o), 32'd0);
    check("reset_dat_o", s_wb_dat_o, 32'd0);
    wb_rst = 1'b0;

    // Classic write then read back, first request right after reset release.
    fix_q.push_back(32'hDEADBEEF);
    do_burst(32'h10, 1'b1, 2'b00, 1, 4'hf, -1, -1);
    do_burst(32'h10, 1'b0, 2'b00, 1, 4'hf, -1, -1);
    check("raw_0x10", s_wb_dat_o, 32'hDEADBEEF);

    // Byte-lane merge.
    fix_q.push_back(32'h11223344);
    do_burst(32'h20, 1'b1, 2'b00, 1, 4'hf, -1, -1);
    fix_q.push_back(32'h0000AA00);
    do_burst(32'h20, 1'b1, 2'b00, 1, 4'b0010, -1, -1);
    do_burst(32'h20, 1'b0, 2'b00, 1, 4'hf, -1, -1);
    check("sel_merge", s_wb_dat_o, 32'h1122AA44);

    // Wrap-4 read starting at word 0x0E: E, F, C, D.
    fix_q.push_back(32'hC0C0_000C); fix_q.push_back(32'hD0D0_000D);
    fix_q.push_back(32'hE0E0_000E); fix_q.push_back(32'hF0F0_000F);
    do_burst(32'h30, 1'b1, 2'b00, 4, 4'hf, -1, -1);
    do_burst(32'h38, 1'b0, 2'b01, 4, 4'hf, -1, -1);
    check("wrap4_last", s_wb_dat_o, 32'hD0D0_000D);

    // Linear burst with a 2-cycle pause after beat 2.
    do_burst(32'h100, 1'b1, 2'b00, 4, 4'hf, -1, -1);
    do_burst(32'h100, 1'b0, 2'b00, 4, 4'hf, 2, -1);

    // Out-of-range read, then a normal read.
    do_burst(BASE_ADR + 32'(N * 4), 1'b0, 2'b00, 1, 4'hf, -1, -1);
    do_burst(32'h10, 1'b0, 2'b00, 1, 4'hf, -1, -1);
    check("after_err_read", s_wb_dat_o, 32'hDEADBEEF);

    // Reset after beat 2 of an 8-beat write over known data, then read back.
    do_burst(32'h200, 1'b1, 2'b00, 8, 4'hf, -1, -1);
    do_burst(32'h200, 1'b1, 2'b00, 8, 4'hf, -1, 2);
    do_burst(32'h200, 1'b0, 2'b00, 8, 4'hf, -1, -1);

    // Randomized bursts.
    for (int t = 0; t < 40; t++) begin
      nb  = ($urandom_range(0, 2) == 0) ? 1 : $urandom_range(2, 8);
      bte = 2'($urandom_range(0, 3));
      wr  = 1'($urandom_range(0, 1));
      sel = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hf;
      if ($urandom_range(0, 9) == 0)
        badr = BASE_ADR + 32'(N * 4) + 32'($urandom_range(0, 1000) * 4);
      else
        badr = BASE_ADR + 32'($urandom_range(0, N - 1) * 4) + 32'($urandom_range(0, 3));
      do_burst(badr, wr, bte, nb, sel,
               ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
